// File: rtl/multicycle_alu_control_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_alu_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic       ir_we;
  logic       pc_we;
  logic       reg_we;
  logic       mem_rd;
  logic       mem_we;
  logic [1:0] pc_src;
  logic [1:0] reg_dst;
  logic [1:0] wb_src;
  logic [2:0] state;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output alu_sel, alu_src_a, alu_src_b, imm_zext,
    output ir_we, pc_we, reg_we, mem_rd, mem_we,
    output pc_src, reg_dst, wb_src,
    output state, instr_done, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  alu_sel, alu_src_a, alu_src_b, imm_zext,
    input  ir_we, pc_we, reg_we, mem_rd, mem_we,
    input  pc_src, reg_dst, wb_src,
    input  state, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_alu_control.sv
// Multi-cycle CPU control FSM: fetch/decode/exec/mem/wb sequencing,
// ALU op select and all datapath enables/selects.
module multicycle_alu_control (
  input logic                      clk,
  input logic                      reset_n,
  multicycle_alu_control_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [2:0] A_ADD = 3'd0;
  localparam logic [2:0] A_SUB = 3'd1;
  localparam logic [2:0] A_XOR = 3'd2;
  localparam logic [2:0] A_SLT = 3'd3;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_SLT = 6'h2A;

  logic [2:0] state_q, state_d;

  logic is_r, is_add, is_sub, is_slt, is_jr;
  logic is_j, is_jal, is_beq, is_bne;
  logic is_addi, is_xori, is_lw, is_sw;
  logic is_bad;

  // Instruction class flags from the (stable) IR fields
  always_comb begin
    is_r    = bus.opcode == OP_R;
    is_add  = is_r && bus.funct == F_ADD;
    is_sub  = is_r && bus.funct == F_SUB;
    is_slt  = is_r && bus.funct == F_SLT;
    is_jr   = is_r && bus.funct == F_JR;
    is_j    = bus.opcode == OP_J;
    is_jal  = bus.opcode == OP_JAL;
    is_beq  = bus.opcode == OP_BEQ;
    is_bne  = bus.opcode == OP_BNE;
    is_addi = bus.opcode == OP_ADDI;
    is_xori = bus.opcode == OP_XORI;
    is_lw   = bus.opcode == OP_LW;
    is_sw   = bus.opcode == OP_SW;
    is_bad  = !(is_add || is_sub || is_slt || is_jr ||
                is_j || is_jal || is_beq || is_bne ||
                is_addi || is_xori || is_lw || is_sw);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state selection
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_j || is_jal || is_jr || is_bad) state_d = S_FETCH;
        else                                   state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_lw, is_sw:                     state_d = S_MEM;
          is_add, is_sub, is_slt,
          is_addi, is_xori:                 state_d = S_WB;
          default:                          state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!bus.mem_ready) state_d = S_MEM;
        else if (is_lw)     state_d = S_WB;
        else                state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Datapath controls; everything held at 0 while in reset
  always_comb begin
    bus.alu_sel    = A_ADD;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'd0;
    bus.imm_zext   = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.reg_we     = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.pc_src     = 2'd0;
    bus.reg_dst    = 2'd0;
    bus.wb_src     = 2'd0;
    bus.state      = S_FETCH;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    if (reset_n) begin
      bus.state = state_q;
      case (state_q)
        S_FETCH: begin
          bus.mem_rd    = 1'b1;
          bus.alu_src_b = 2'd1;
          bus.ir_we     = bus.mem_ready;
          bus.pc_we     = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_b = 2'd3;
          unique case (1'b1)
            is_j: begin
              bus.pc_we      = 1'b1;
              bus.pc_src     = 2'd2;
              bus.instr_done = 1'b1;
            end
            is_jal: begin
              bus.pc_we      = 1'b1;
              bus.pc_src     = 2'd2;
              bus.reg_we     = 1'b1;
              bus.reg_dst    = 2'd2;
              bus.wb_src     = 2'd2;
              bus.instr_done = 1'b1;
            end
            is_jr: begin
              bus.pc_we      = 1'b1;
              bus.pc_src     = 2'd3;
              bus.instr_done = 1'b1;
            end
            is_bad: begin
              bus.illegal    = 1'b1;
              bus.instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          unique case (1'b1)
            is_add: bus.alu_sel = A_ADD;
            is_sub: bus.alu_sel = A_SUB;
            is_slt: bus.alu_sel = A_SLT;
            is_addi, is_lw, is_sw: begin
              bus.alu_src_b = 2'd2;
            end
            is_xori: begin
              bus.alu_src_b = 2'd2;
              bus.imm_zext  = 1'b1;
              bus.alu_sel   = A_XOR;
            end
            is_beq, is_bne: begin
              bus.alu_sel    = A_SUB;
              bus.pc_src     = 2'd1;
              bus.pc_we      = is_beq ? bus.zero : !bus.zero;
              bus.instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          unique case (1'b1)
            is_lw: bus.mem_rd = 1'b1;
            is_sw: begin
              bus.mem_we     = 1'b1;
              bus.instr_done = bus.mem_ready;
            end
            default: ;
          endcase
        end
        S_WB: begin
          bus.reg_we     = 1'b1;
          bus.instr_done = 1'b1;
          bus.reg_dst    = is_r ? 2'd1 : 2'd0;
          bus.wb_src     = is_lw ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
